// File: rtl/dbus_mem_responder_pkg.sv
// dbus_mem_responder_pkg
//   Shared types for the data-bus responder: request/response structures,
//   scalar bus types, the responder state enum and a byte-merge helper.
//   No ports (package).
package dbus_mem_responder_pkg;

   typedef logic [63:0] addr_t;
   typedef logic [63:0] word_t;
   typedef logic [7:0]  strobe_t;
   typedef logic [2:0]  msize_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } rsp_state_e;

   // Replace the bytes of old_w selected by strb with the matching bytes of new_w.
   function automatic word_t byte_merge(input word_t old_w, input word_t new_w, input strobe_t strb);
      word_t res;
      res = old_w;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dbus_mem_responder_byte_strobe_mem.sv
// dbus_mem_responder_byte_strobe_mem
//   DEPTH x 64-bit word memory with one read/write port, per-byte write enable
//   and a registered read. The read register only carries a word in the cycle
//   after an access and is zero otherwise, so it can drive the bus data
//   directly.
//   Ports:
//     clk     rising-edge clock
//     reset   asynchronous active-low reset (read register only; array is not reset)
//     en      perform an access at this edge
//     idx     word index
//     strobe  per-byte write enable (all zero = pure read)
//     wdata   write data
//     rdata   word read at the last access edge (value before that access's write), else 0
module dbus_mem_responder_byte_strobe_mem
   import dbus_mem_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [AW-1:0] idx,
   input  strobe_t       strobe,
   input  word_t         wdata,
   output word_t         rdata
);

   word_t mem_r [DEPTH];
   word_t rdata_r;

   // Storage array write with byte-lane merge.
   always_ff @(posedge clk) begin
      if (en && (strobe != 8'h00)) begin
         mem_r[idx] <= byte_merge(mem_r[idx], wdata, strobe);
      end
   end

   // Read register: old word on an access edge, cleared otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_r <= 64'h0;
      end else if (en) begin
         rdata_r <= mem_r[idx];
      end else begin
         rdata_r <= 64'h0;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder
//   Data-bus responder serving one transaction at a time from an internal
//   word memory, answering LATENCY cycles after acceptance.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     dreq   request (valid, addr, size, strobe, data)
//     dresp  response (addr_ok combinational in IDLE, data_ok/data in RESP)
//     oob    high with data_ok when the served address was outside the window
module dbus_mem_responder
   import dbus_mem_responder_pkg::*;
#(
   parameter addr_t BASE    = 64'h8000_0000,
   parameter int    DEPTH   = 1024,
   parameter int    LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       oob
);

   localparam int         AW       = $clog2(DEPTH);
   localparam addr_t      WINDOW   = addr_t'(DEPTH) * 64'd8;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   rsp_state_e    state_r;
   rsp_state_e    state_s;
   logic [3:0]    cnt_r;
   addr_t         lat_addr_r;
   strobe_t       lat_strobe_r;
   word_t         lat_data_r;
   msize_t        lat_size_r;
   logic          oob_r;

   logic          accept_s;
   logic          enter_resp_s;
   logic          in_range_s;
   logic          mem_en_s;
   addr_t         acc_addr_s;
   addr_t         off_s;
   strobe_t       acc_strobe_s;
   word_t         acc_data_s;
   word_t         rdata_s;
   logic [AW-1:0] idx_s;
   logic          unused_s;

   // Gating with reset keeps addr_ok low and blocks any access while reset is held.
   assign accept_s = reset & (state_r == IDLE) & dreq.valid;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (LATENCY == 32'sd1) begin
                  state_s = RESP;
               end else begin
                  state_s = WAIT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 4'd1) begin
               state_s = RESP;
            end else begin
               state_s = WAIT;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // RESP always returns to IDLE, so heading for RESP always means entering it.
   assign enter_resp_s = (state_s == RESP);

   // Access operands: with LATENCY=1 the access edge is the acceptance edge,
   // so the operands must come straight from the bus rather than the latch.
   always_comb begin
      if (state_r == IDLE) begin
         acc_addr_s   = dreq.addr;
         acc_strobe_s = dreq.strobe;
         acc_data_s   = dreq.data;
      end else begin
         acc_addr_s   = lat_addr_r;
         acc_strobe_s = lat_strobe_r;
         acc_data_s   = lat_data_r;
      end
   end

   assign off_s      = acc_addr_s - BASE;
   assign in_range_s = (acc_addr_s >= BASE) && (off_s < WINDOW);
   assign idx_s      = off_s[AW+2:3];
   assign mem_en_s   = enter_resp_s & in_range_s;

   // size and the sub-word / above-window offset bits play no part in the access.
   assign unused_s = ^{lat_size_r, off_s[63:AW+3], off_s[2:0]};

   // Request latch and latency countdown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r        <= 4'd0;
         lat_addr_r   <= 64'h0;
         lat_strobe_r <= 8'h00;
         lat_data_r   <= 64'h0;
         lat_size_r   <= 3'd0;
      end else if (accept_s) begin
         cnt_r        <= CNT_LOAD;
         lat_addr_r   <= dreq.addr;
         lat_strobe_r <= dreq.strobe;
         lat_data_r   <= dreq.data;
         lat_size_r   <= dreq.size;
      end else if (state_r == WAIT) begin
         cnt_r        <= cnt_r - 4'd1;
      end else begin
         cnt_r        <= cnt_r;
      end
   end

   // Out-of-window flag, valid only in the RESP cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         oob_r <= 1'b0;
      end else begin
         oob_r <= enter_resp_s & ~in_range_s;
      end
   end

   dbus_mem_responder_byte_strobe_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk    (clk),
      .reset  (reset),
      .en     (mem_en_s),
      .idx    (idx_s),
      .strobe (acc_strobe_s),
      .wdata  (acc_data_s),
      .rdata  (rdata_s)
   );

   // Response outputs; rdata_s is already zero outside the RESP cycle.
   always_comb begin
      dresp.addr_ok = accept_s;
      dresp.data_ok = (state_r == RESP);
      dresp.data    = rdata_s;
      oob           = oob_r;
   end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb_dbus_mem_responder
//   Two responders (LATENCY=2 and LATENCY=1) checked every cycle against a
//   transaction-level model, plus directed scenarios with literal results.
module tb_dbus_mem_responder;
   import dbus_mem_responder_pkg::*;

   localparam addr_t BASE    = 64'h8000_0000;
   localparam int    DEPTH   = 1024;
   localparam addr_t WIN_END = 64'h8000_2000;

   logic       clk = 1'b0;
   logic       rst_n;
   dbus_req_t  dreq_a  [2];
   dbus_resp_t dresp_a [2];
   logic       oob_a   [2];

   int cyc     = 0;
   int n_pass  = 0;
   int n_total = 0;

   // model state
   word_t   mm   [2][DEPTH];
   bit      mk   [2][DEPTH];
   bit      pend [2];
   int      resp_cyc  [2];
   int      next_free [2];
   addr_t   p_addr [2];
   strobe_t p_strb [2];
   word_t   p_data [2];

   dbus_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
      .clk(clk), .reset(rst_n), .dreq(dreq_a[0]), .dresp(dresp_a[0]), .oob(oob_a[0]));
   dbus_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst_n), .dreq(dreq_a[1]), .dresp(dresp_a[1]), .oob(oob_a[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Transaction-level model and per-cycle comparison for both responders.
   always @(negedge clk) begin : model_cmp
      bit    eaok, eok, eoo, cd, inr;
      word_t ed;
      int    ix;
      if (cyc > 0) begin
         for (int k = 0; k < 2; k++) begin
            eaok = 1'b0; eok = 1'b0; eoo = 1'b0; ed = 64'h0; cd = 1'b1;
            if (!rst_n) begin
               pend[k] = 1'b0;
               next_free[k] = 0;
            end else begin
               eaok = dreq_a[k].valid && (cyc >= next_free[k]);
               eok  = pend[k] && (cyc == resp_cyc[k]);
               if (eok) begin
                  inr = (p_addr[k] >= BASE) && (p_addr[k] < WIN_END);
                  if (inr) begin
                     ix = int'((p_addr[k] - BASE) >> 3);
                     ed = mm[k][ix];
                     cd = mk[k][ix];
                     for (int b = 0; b < 8; b++)
                        if (p_strb[k][b]) mm[k][ix][8*b +: 8] = p_data[k][8*b +: 8];
                     if (p_strb[k] == 8'hFF) mk[k][ix] = 1'b1;
                  end else begin
                     eoo = 1'b1;
                  end
                  pend[k] = 1'b0;
               end
               if (eaok) begin
                  pend[k]      = 1'b1;
                  resp_cyc[k]  = cyc + lat_of(k);
                  next_free[k] = cyc + lat_of(k) + 1;
                  p_addr[k]    = dreq_a[k].addr;
                  p_strb[k]    = dreq_a[k].strobe;
                  p_data[k]    = dreq_a[k].data;
               end
            end
            chk($sformatf("addr_ok[%0d]", k), 64'(dresp_a[k].addr_ok), 64'(eaok));
            chk($sformatf("data_ok[%0d]", k), 64'(dresp_a[k].data_ok), 64'(eok));
            chk($sformatf("oob[%0d]", k), 64'(oob_a[k]), 64'(eoo));
            if (cd) chk($sformatf("data[%0d]", k), dresp_a[k].data, ed);
         end
      end
   end

   // One request on responder k; returns data/oob and accept / data_ok cycles.
   task automatic txn(input int k, input addr_t a, input strobe_t s, input word_t d, input bit wiggle,
                      output word_t rd, output logic ro, output int ta, output int tk);
      ta = -1; tk = -1; rd = 64'h0; ro = 1'b0;
      @(posedge clk); #1;
      dreq_a[k].valid = 1'b1; dreq_a[k].addr = a; dreq_a[k].size = 3'd3;
      dreq_a[k].strobe = s; dreq_a[k].data = d;
      for (int n = 0; n < 40 && tk < 0; n++) begin
         @(negedge clk);
         if (ta < 0) begin
            if (dresp_a[k].addr_ok) ta = cyc;
         end else if (dresp_a[k].data_ok) begin
            tk = cyc; rd = dresp_a[k].data; ro = oob_a[k];
         end
         if (ta >= 0) begin
            @(posedge clk); #1;
            if (wiggle && tk < 0) begin
               dreq_a[k].addr = a + 64'd8; dreq_a[k].strobe = 8'h00; dreq_a[k].data = ~d;
            end else begin
               dreq_a[k].valid = 1'b0;
            end
         end
      end
      dreq_a[k].valid = 1'b0;
      if (tk < 0) begin
         n_total++;
         $display("FAIL txn_timeout: responder %0d addr %h got no data_ok, required within 40 cycles", k, a);
      end
   endtask

   function automatic addr_t pick_addr();
      int r;
      r = $urandom_range(0, 15);
      case (r)
         12:      return BASE - 64'd8;
         13:      return WIN_END;
         14:      return WIN_END - 64'd8;
         15:      return 64'hFFFF_FFFF_FFFF_FFF8;
         default: return BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
      endcase
   endfunction

   task automatic rand_drive(input int k);
      int p;
      for (int n = 0; n < 1500; n++) begin
         @(posedge clk); #1;
         p = $urandom_range(0, 3);
         dreq_a[k].valid = (p != 0);
         dreq_a[k].addr  = pick_addr();
         dreq_a[k].size  = 3'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       dreq_a[k].strobe = 8'h00;
            1:       dreq_a[k].strobe = 8'hFF;
            default: dreq_a[k].strobe = 8'($urandom);
         endcase
         dreq_a[k].data = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      dreq_a[k].valid = 1'b0;
   endtask

   initial begin
      word_t rd;
      logic  ro;
      int    ta, tk, nacc, nok, overlap;
      int    acc_t [3];
      int    ok_t  [3];
      addr_t b_addr [3];
      word_t b_data [3];

      rst_n = 1'b0;
      dreq_a[0] = '0;
      dreq_a[1] = '0;
      dreq_a[0].valid = 1'b1;   // addr_ok must stay low under reset even with valid
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_addr_ok", 64'(dresp_a[0].addr_ok), 64'd0);
      chk("rst_data_ok", 64'(dresp_a[0].data_ok), 64'd0);
      chk("rst_data", dresp_a[0].data, 64'h0);
      chk("rst_oob", 64'(oob_a[0]), 64'd0);
      @(posedge clk); #1;
      dreq_a[0].valid = 1'b0;
      rst_n = 1'b1;

      // write then read, LATENCY=2
      txn(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, rd, ro, ta, tk);
      chk("wr_latency", 64'(tk - ta), 64'd2);
      txn(0, 64'h8000_0010, 8'h00, 64'hFFFF_0000_FFFF_0000, 1'b0, rd, ro, ta, tk);
      chk("rd_after_wr", rd, 64'h1122_3344_5566_7788);
      chk("rd_latency", 64'(tk - ta), 64'd2);

      // partial write
      txn(0, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, rd, ro, ta, tk);
      txn(0, 64'h8000_0013, 8'h00, 64'h0, 1'b0, rd, ro, ta, tk);
      chk("partial_wr", rd, 64'h1122_3344_AAAA_AAAA);

      // out of window
      txn(0, BASE, 8'hFF, 64'hCAFE_F00D_0123_4567, 1'b0, rd, ro, ta, tk);
      txn(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 1'b0, rd, ro, ta, tk);
      chk("oob_rd_data", rd, 64'h0);
      chk("oob_rd_flag", 64'(ro), 64'd1);
      chk("oob_rd_latency", 64'(tk - ta), 64'd2);
      txn(0, WIN_END, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, rd, ro, ta, tk);
      chk("oob_wr_flag", 64'(ro), 64'd1);
      txn(0, BASE, 8'h00, 64'h0, 1'b0, rd, ro, ta, tk);
      chk("base_unchanged", rd, 64'hCAFE_F00D_0123_4567);
      chk("base_oob_flag", 64'(ro), 64'd0);

      // request changes during WAIT are ignored
      txn(0, 64'h8000_0020, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b1, rd, ro, ta, tk);
      txn(0, 64'h8000_0020, 8'h00, 64'h0, 1'b0, rd, ro, ta, tk);
      chk("wait_ignored", rd, 64'h0F0E_0D0C_0B0A_0908);

      // reset during WAIT drops a pending write
      txn(0, 64'h8000_0030, 8'hFF, 64'h5555_6666_7777_8888, 1'b0, rd, ro, ta, tk);
      @(posedge clk); #1;
      dreq_a[0].valid = 1'b1; dreq_a[0].addr = 64'h8000_0030;
      dreq_a[0].strobe = 8'hFF; dreq_a[0].data = 64'h0123_4567_89AB_CDEF;
      ta = -1;
      for (int n = 0; n < 20 && ta < 0; n++) begin
         @(negedge clk);
         if (dresp_a[0].addr_ok) ta = cyc;
      end
      if (ta < 0) begin
         n_total++;
         $display("FAIL rst_accept_timeout: got no addr_ok, required within 20 cycles");
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_addr_ok", 64'(dresp_a[0].addr_ok), 64'd0);
      chk("rst_mid_data_ok", 64'(dresp_a[0].data_ok), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      dreq_a[0].valid = 1'b0;
      rst_n = 1'b1;
      txn(0, 64'h8000_0030, 8'h00, 64'h0, 1'b0, rd, ro, ta, tk);
      chk("rst_no_commit", rd, 64'h5555_6666_7777_8888);

      // back-to-back with valid held, LATENCY=1
      b_addr[0] = BASE + 64'h40; b_data[0] = 64'h0101_0101_0101_0101;
      b_addr[1] = BASE + 64'h48; b_data[1] = 64'h0202_0202_0202_0202;
      b_addr[2] = BASE + 64'h50; b_data[2] = 64'h0303_0303_0303_0303;
      nacc = 0; nok = 0; overlap = 0;
      @(posedge clk); #1;
      dreq_a[1].valid = 1'b1; dreq_a[1].addr = b_addr[0];
      dreq_a[1].strobe = 8'hFF; dreq_a[1].data = b_data[0];
      for (int n = 0; n < 30 && nok < 3; n++) begin
         @(negedge clk);
         if (dresp_a[1].addr_ok && dresp_a[1].data_ok) overlap++;
         if (dresp_a[1].addr_ok && nacc < 3) begin acc_t[nacc] = cyc; nacc++; end
         if (dresp_a[1].data_ok && nok < 3) begin ok_t[nok] = cyc; nok++; end
         @(posedge clk); #1;
         if (nacc < 3) begin
            dreq_a[1].addr = b_addr[nacc]; dreq_a[1].data = b_data[nacc];
         end else begin
            dreq_a[1].valid = 1'b0;
         end
      end
      dreq_a[1].valid = 1'b0;
      if (nok == 3) begin
         chk("b2b_ok0", 64'(ok_t[0] - acc_t[0]), 64'd1);
         chk("b2b_ok1", 64'(ok_t[1] - acc_t[0]), 64'd3);
         chk("b2b_ok2", 64'(ok_t[2] - acc_t[0]), 64'd5);
      end else begin
         n_total++;
         $display("FAIL b2b_timeout: got %0d data_ok pulses, required 3", nok);
      end
      chk("b2b_no_overlap", 64'(overlap), 64'd0);
      txn(1, BASE + 64'h48, 8'h00, 64'h0, 1'b0, rd, ro, ta, tk);
      chk("b2b_readback", rd, 64'h0202_0202_0202_0202);
      chk("lat1_latency", 64'(tk - ta), 64'd1);

      // randomized traffic on both responders
      fork
         rand_drive(0);
         rand_drive(1);
      join
      repeat (6) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
